display_driver: RTL and testbench
=================================

Name: display_driver

Overview:
- Consumer end of the register file's display port: takes the 32-bit value of register 31 and drives a bank of active-low 7-segment digits with its decimal representation.
- Conversion is iterative double-dabble (shift-and-add-3), one bit per clock, 32 iterations.
- A new conversion starts automatically when the input value differs from the last value displayed.
- Sits between the register file's display output and the board HEX pins.

Parameters:
- DIGITS, 8, number of 7-segment digits driven; legal range 1..10.
- BLANK_LEADING, 1, 1 = leading zeros blanked (digit 0 always lit); 0 = all digits shown.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- reset_n  input  1  synchronous, active-low reset; sampled on the clock rising edge.
- toDisplay  input  32  value to show; unsigned unless SIGNED_DISPLAY_EN is defined.
- segments  output  7*DIGITS  registered; digit k occupies bits [7k+6:7k], bit order {g,f,e,d,c,b,a}, active-low.
- busy  output  1  registered; high while in CONVERT or UPDATE.
- done  output  1  registered; one-cycle pulse after segments change.
- overflow  output  1  registered; high while the displayed value does not fit in DIGITS digits.

Behaviour:
- Reset (reset_n low at an edge):
  - segments all 1 (blank); busy, done and overflow 0.
  - State is IDLE, shift counter 0, shown_valid flag 0.
- FSM states: IDLE, CONVERT, UPDATE.
- IDLE:
  - If shown_valid==0 or toDisplay != last_value at edge E, capture toDisplay into the binary shift register and last_value, clear the 40-bit BCD register and counter, busy=1, go to CONVERT.
  - Otherwise hold.
- CONVERT, edges E+1..E+32:
  - Each BCD nibble >=5 gets +3, then {bcd,bin} shifts left 1.
  - Counter increments; after the 32nd shift go to UPDATE.
- UPDATE, edge E+33:
  - Register segments from the BCD result, set shown_valid=1, go to IDLE, busy=0, done=1 for exactly the following cycle.
  - Total latency is 33 edges from capture to new segments.
- Input changes during CONVERT/UPDATE are ignored. The comparison is re-evaluated in IDLE, so the earliest next capture is E+34.
- Overflow: any BCD digit at index >= DIGITS nonzero sets overflow=1, and every digit shows a dash (7'b0111111).
- Encodings: '0'..'9' use standard active-low patterns ('0'=7'b1000000, '8'=7'b0000000); blank=7'b1111111.
- Leading-zero blanking: zero digits above the most significant nonzero digit are blank; digit 0 is never blanked (value 0 shows "0").
- Reset mid-conversion aborts with no done pulse. segments go blank, and the first IDLE cycle after reset starts a fresh conversion.
- reset_n has priority over all other activity at an edge.

Optional Feature:
- SIGNED_DISPLAY_EN defined:
  - toDisplay is two's complement. If bit 31 is set, the magnitude (negated, as 32-bit unsigned; -2^31 gives 2147483648) is converted.
  - Digit DIGITS-1 shows minus (7'b0111111); the magnitude must fit in DIGITS-1 digits, else overflow.
  - Latency unchanged: negation happens at capture.
- Undefined: unsigned only; no sign logic.

Decomposition:
- Package mips_display_pkg holds:
  - FSM state typedef (IDLE/CONVERT/UPDATE).
  - Segment constants SEG_BLANK, SEG_DASH, SEG_MINUS.
  - BCD_DIGITS=10 and CONV_BITS=32.
- One sub-module, seg7_decode: combinational 4-bit BCD to 7-bit active-low pattern, instantiated DIGITS times.

Test Plan:
- Release reset with toDisplay=0: busy at edge 1, done pulse after 33 edges; digit0=7'b1000000, digits 1..7 blank, overflow=0.
- toDisplay=12345678: digits 7..0 show 1,2,3,4,5,6,7,8; busy high for exactly 33 cycles.
- toDisplay=99999999 shows no overflow. Then 100000000: overflow=1, all digits 7'b0111111. Then 0xFFFFFFFF: overflow stays 1.
- Change toDisplay 5 -> 42 mid-CONVERT (edge E+10): result still shows 5 at E+33, then a second conversion starts at E+34 and shows 42 at E+67.
- Assert reset_n low at E+20 for one edge: no done pulse, segments blank; the conversion restarts on release and completes 33 edges later.
- With SIGNED_DISPLAY_EN, toDisplay=0xFFFFFFFB: digit7 minus, digit0 '5', others blank. With 0x80000000 and DIGITS=8: overflow=1.

Source files
------------

// File: rtl/mips_display_pkg.sv
// Shared definitions for the register-31 display path.
//   - state_t      : converter FSM states (idle / shifting / result update)
//   - SEG_*        : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   - BCD_DIGITS   : width of the BCD accumulator in decimal digits
//   - CONV_BITS    : binary input width, also the number of shift iterations
//   - bcd_adjust() : one double-dabble correction step (+3 on nibbles >= 5)
package mips_display_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StConvert,
      StUpdate
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;

   // 2^32-1 has ten decimal digits.
   localparam int unsigned BCD_DIGITS = 10;
   localparam int unsigned CONV_BITS  = 32;

   // Add 3 to every nibble that is 5 or more, so the following left shift
   // carries correctly into the next decimal digit.
   function automatic logic [4*BCD_DIGITS-1:0] bcd_adjust(input logic [4*BCD_DIGITS-1:0] bcd);
      logic [4*BCD_DIGITS-1:0] res;
      logic [3:0]              nib;
      res = bcd;
      for (int i = 0; i < int'(BCD_DIGITS); i++) begin
         nib = bcd[4*i +: 4];
         if (nib >= 4'd5) begin
            res[4*i +: 4] = nib + 4'd3;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern.
// Ports:
//   bcd : 4-bit decimal digit (values above 9 decode to blank)
//   seg : active-low segments, bit order {g,f,e,d,c,b,a}
module seg7_decode
   import mips_display_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/display_driver.sv
// Drives a bank of active-low 7-segment digits with the decimal value of the
// register file's display port (register 31). Binary to BCD uses iterative
// double-dabble, one bit per clock; a conversion starts whenever the input
// differs from the last value shown, and new segments appear 33 edges after
// capture.
//
// Optional build macro: SIGNED_DISPLAY_EN
//   defined   : toDisplay is two's complement; negatives show a minus sign in
//               the top digit and the magnitude must fit in DIGITS-1 digits.
//   undefined : unsigned display only.
//
// Parameters:
//   DIGITS        : number of digits driven (1..10)
//   BLANK_LEADING : 1 = blank leading zeros (digit 0 always lit)
// Ports:
//   clock     : system clock, rising edge
//   reset_n   : synchronous active-low reset
//   toDisplay : value to show
//   segments  : digit k at [7k+6:7k], {g,f,e,d,c,b,a}, active-low, registered
//   busy      : high while converting or updating
//   done      : one-cycle pulse after segments change
//   overflow  : displayed value does not fit in the available digits
module display_driver
   import mips_display_pkg::*;
#(
   parameter int unsigned DIGITS        = 8,
   parameter bit          BLANK_LEADING = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic [31:0]           toDisplay,
   output logic [7*DIGITS-1:0]   segments,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow
);

   state_t                  state_q, state_d;
   logic [CONV_BITS-1:0]    bin_q;
   logic [31:0]             last_q;
   logic [4*BCD_DIGITS-1:0] bcd_q;
   logic [4*BCD_DIGITS-1:0] bcd_adj;
   logic [5:0]              cnt_q;
   logic                    shown_q;
   logic                    start;
   logic [31:0]             capture_val;
   logic                    is_neg;

   logic [6:0]              dec [DIGITS];
   logic [7*DIGITS-1:0]     seg_res;
   logic                    ovf_res;
   logic                    busy_d;
   logic                    done_d;

   // Re-evaluated only in idle, so input changes mid-conversion are ignored.
   assign start   = (state_q == StIdle) && (!shown_q || (toDisplay != last_q));
   assign bcd_adj = bcd_adjust(bcd_q);

`ifdef SIGNED_DISPLAY_EN
   logic neg_q;

   // Negate at capture so the shift loop always sees a magnitude; -2^31
   // wraps to 0x80000000, which is exactly its magnitude as unsigned.
   assign capture_val = toDisplay[31] ? (~toDisplay + 32'd1) : toDisplay;
   assign is_neg      = neg_q;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         neg_q <= 1'b0;
      end else if (start) begin
         neg_q <= toDisplay[31];
      end
   end
`else
   assign capture_val = toDisplay;
   assign is_neg      = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StConvert;
            end
         end
         StConvert: begin
            if (cnt_q == 6'(CONV_BITS - 1)) begin
               state_d = StUpdate;
            end
         end
         StUpdate: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Conversion datapath.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         bin_q   <= '0;
         last_q  <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         shown_q <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  bin_q  <= capture_val;
                  last_q <= toDisplay;
                  bcd_q  <= '0;
                  cnt_q  <= '0;
               end
            end
            StConvert: begin
               {bcd_q, bin_q} <= {bcd_adj[4*BCD_DIGITS-2:0], bin_q, 1'b0};
               cnt_q          <= cnt_q + 6'd1;
            end
            StUpdate: shown_q <= 1'b1;
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dec
      seg7_decode u_dec (
         .bcd (bcd_q[4*g +: 4]),
         .seg (dec[g])
      );
   end

   // FSM outputs and the segment image built from the finished BCD result.
   always_comb begin
      int   fit;
      logic nz;

      busy_d  = (state_d != StIdle);
      done_d  = (state_q == StUpdate);

      // A negative value gives up the top digit to the minus sign.
      fit     = is_neg ? int'(DIGITS) - 1 : int'(DIGITS);
      ovf_res = 1'b0;
      for (int k = 0; k < int'(BCD_DIGITS); k++) begin
         if ((k >= fit) && (bcd_q[4*k +: 4] != 4'd0)) begin
            ovf_res = 1'b1;
         end
      end

      // Walk down from the top digit; nz marks that a nonzero digit has been
      // seen at or above the current position.
      nz      = 1'b0;
      seg_res = '1;
      for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
         nz = nz | (bcd_q[4*k +: 4] != 4'd0);
         if (ovf_res) begin
            seg_res[7*k +: 7] = SEG_DASH;
         end else if (is_neg && (k == int'(DIGITS) - 1)) begin
            seg_res[7*k +: 7] = SEG_MINUS;
         end else if (nz || (k == 0) || !BLANK_LEADING) begin
            seg_res[7*k +: 7] = dec[k];
         end else begin
            seg_res[7*k +: 7] = SEG_BLANK;
         end
      end
   end

   // Registered outputs.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         segments <= '1;
         busy     <= 1'b0;
         done     <= 1'b0;
         overflow <= 1'b0;
      end else begin
         busy <= busy_d;
         done <= done_d;
         if (state_q == StUpdate) begin
            segments <= seg_res;
            overflow <= ovf_res;
         end
      end
   end

endmodule

// File: tb/tb_display_driver.sv
module tb_display_driver;

   logic        clock;
   logic        reset_n;
   logic [31:0] toDisplay;
   logic [55:0] segments;
   logic        busy;
   logic        done;
   logic        overflow;

   int checks = 0;
   int errors = 0;

   display_driver #(
      .DIGITS        (8),
      .BLANK_LEADING (1'b1)
   ) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .toDisplay (toDisplay),
      .segments  (segments),
      .busy      (busy),
      .done      (done),
      .overflow  (overflow)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] val;
      logic [55:0] seg;
      logic        ovf;
   } vec_t;

   vec_t vecs[$];

   // Build an expected segment image from an 8-character string, leftmost
   // character = digit 7. ' ' blank, '-' dash/minus.
   function automatic logic [55:0] mk(input string s);
      logic [55:0] r;
      byte         c;
      r = '1;
      for (int i = 0; i < 8; i++) begin
         c = s[7-i];
         case (c)
            "0": r[7*i +: 7] = 7'b1000000;
            "1": r[7*i +: 7] = 7'b1111001;
            "2": r[7*i +: 7] = 7'b0100100;
            "3": r[7*i +: 7] = 7'b0110000;
            "4": r[7*i +: 7] = 7'b0011001;
            "5": r[7*i +: 7] = 7'b0010010;
            "6": r[7*i +: 7] = 7'b0000010;
            "7": r[7*i +: 7] = 7'b1111000;
            "8": r[7*i +: 7] = 7'b0000000;
            "9": r[7*i +: 7] = 7'b0010000;
            "-": r[7*i +: 7] = 7'b0111111;
            default: r[7*i +: 7] = 7'b1111111;
         endcase
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Count edges until done is seen (including the capture edge) and how many
   // of those samples had busy high.
   task automatic conv_wait(output int n, output int nb);
      n  = 0;
      nb = 0;
      for (int i = 0; i < 200; i++) begin
         @(posedge clock);
         #1;
         n++;
         if (busy) nb++;
         if (done) return;
      end
      checks++;
      errors++;
      $display("FAIL conv_wait: no done pulse within %0d edges", n);
   endtask

   function automatic vec_t mkv(input logic [31:0] v, input string s, input logic o);
      vec_t r;
      r.val = v;
      r.seg = mk(s);
      r.ovf = o;
      return r;
   endfunction

   initial begin
      int n, nb;

      vecs.push_back(mkv(32'd12345678, "12345678", 1'b0));
      vecs.push_back(mkv(32'd99999999, "99999999", 1'b0));
      vecs.push_back(mkv(32'd100000000, "--------", 1'b1));
`ifdef SIGNED_DISPLAY_EN
      vecs.push_back(mkv(32'hFFFFFFFF, "-      1", 1'b0));
      vecs.push_back(mkv(32'hFFFFFFFB, "-      5", 1'b0));
      vecs.push_back(mkv(32'h80000000, "--------", 1'b1));
      vecs.push_back(mkv(32'hFF676981, "-9999999", 1'b0));
`else
      vecs.push_back(mkv(32'hFFFFFFFF, "--------", 1'b1));
      vecs.push_back(mkv(32'h80000000, "--------", 1'b1));
`endif
      vecs.push_back(mkv(32'd10000000, "10000000", 1'b0));
      vecs.push_back(mkv(32'd1000, "    1000", 1'b0));
      vecs.push_back(mkv(32'd90, "      90", 1'b0));
      vecs.push_back(mkv(32'd7, "       7", 1'b0));

      // Reset state.
      reset_n   = 1'b0;
      toDisplay = 32'd0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_segments", 64'(segments), {8'h0, {56{1'b1}}});
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_overflow", 64'(overflow), 64'd0);

      // First conversion after reset with value 0.
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      chk("first_busy_edge1", 64'(busy), 64'd1);
      conv_wait(n, nb);
      chk("first_latency", 64'(n), 64'd33);
      chk("first_busy_cycles", 64'(nb + 1), 64'd33);
      chk("first_segments", 64'(segments), 64'(mk("       0")));
      chk("first_overflow", 64'(overflow), 64'd0);

      // Table of conversions.
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clock);
         toDisplay = vecs[i].val;
         conv_wait(n, nb);
         chk($sformatf("vec%0d_latency", i), 64'(n), 64'd34);
         chk($sformatf("vec%0d_busy_cycles", i), 64'(nb), 64'd33);
         chk($sformatf("vec%0d_segments", i), 64'(segments), 64'(vecs[i].seg));
         chk($sformatf("vec%0d_overflow", i), 64'(overflow), 64'(vecs[i].ovf));
         @(posedge clock);
         #1;
         chk($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      end

      // Unchanged input: no new conversion.
      repeat (5) @(posedge clock);
      #1;
      chk("hold_busy", 64'(busy), 64'd0);
      chk("hold_segments", 64'(segments), 64'(mk("       7")));

      // Input change mid-conversion is deferred.
      @(negedge clock);
      toDisplay = 32'd5;
      repeat (10) @(posedge clock);
      #1;
      toDisplay = 32'd42;
      conv_wait(n, nb);
      chk("mid_first_latency", 64'(n), 64'd24);
      chk("mid_first_segments", 64'(segments), 64'(mk("       5")));
      conv_wait(n, nb);
      chk("mid_second_latency", 64'(n), 64'd34);
      chk("mid_second_busy", 64'(nb), 64'd33);
      chk("mid_second_segments", 64'(segments), 64'(mk("      42")));

      // Reset mid-conversion aborts, then restarts.
      @(negedge clock);
      toDisplay = 32'd1000;
      repeat (20) @(posedge clock);
      #1;
      chk("abort_busy_before", 64'(busy), 64'd1);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      chk("abort_segments", 64'(segments), {8'h0, {56{1'b1}}});
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      @(negedge clock);
      reset_n = 1'b1;
      conv_wait(n, nb);
      chk("restart_latency", 64'(n), 64'd34);
      chk("restart_busy", 64'(nb), 64'd33);
      chk("restart_segments", 64'(segments), 64'(mk("    1000")));
      chk("restart_overflow", 64'(overflow), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
